fp_add_seq: RTL
===============

// Module: fp_add_seq
// PURPOSE
//  Multi-cycle IEEE-754 single-precision adder/subtractor on the floatingpoint::float type.
//  It is the arithmetic stage fed by operand producers and consumed by result/compare logic.
//  Valid/ready on both sides; one operation in flight; special operands resolved via package classifiers.
// PARAMETERS
//  CANON_NAN   32'h7FC0_0000   bit pattern returned for every NaN result
//  FTZ         1               1: denormal inputs read as signed zero, tiny results flush to signed zero
// PORTS
//  clk        in   1    single clock, all state updates on posedge
//  reset      in   1    synchronous, active-high
//  in_valid   in   1    operands a/b/sub present
//  in_ready   out  1    block can accept operands (high only in IDLE)
//  a          in   32   operand A (floatingpoint::float)
//  b          in   32   operand B (floatingpoint::float)
//  sub        in   1    1: compute a-b (b.sign inverted at capture)
//  out_valid  out  1    result/flags valid
//  out_ready  in   1    consumer accepts result
//  result     out  32   sum (floatingpoint::float)
//  flags      out  4    {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1 in the cycle after reset deasserts, out_valid=0, result=0, flags=0. Reset mid-op discards the operation with no output.
//  - Accept when in_valid&&in_ready; a, b, sub are registered; in_ready drops the next cycle.
//  - FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
//  - UNPACK checks special cases. If either operand is a NaN, or the operation is inf-inf, jump to DONE with CANON_NAN and invalid=1.
//    Any other inf operand: jump to DONE with that inf.
//  - Normal path: accept to out_valid = 6 cycles (the cycle of acceptance counts as cycle 0). Special path: 2 cycles.
//  - UNPACK: insert the hidden 1 for nonzero normal operands. Swap so that |A|>=|B|, comparing {exp,mant}.
//  - ALIGN: right-shift the B significand by expA-expB into a 27-bit value {1,23 mant,G,R,S}. Shifts >=26 leave only the sticky bit.
//  - ADD: add or subtract by effective sign into a 28-bit value. Result sign = sign of A.
//    An exact zero gives +0, or -0 only when both operands are -0 (after sub inversion).
//  - NORM: on carry out, right-shift by 1, fold into sticky, exp+1. Otherwise left-shift by the leading-zero count, exp-lzc.
//    The lzc is combinational over the 27-bit value, done in one cycle.
//  - ROUND: round to nearest, ties to even, using G/R/S. A mantissa carry increments exp.
//    inexact = G|R|S.
//    exp>=255 -> inf of the same sign, overflow=1, inexact=1.
//    exp<=0 with FTZ=1 -> signed zero, underflow=1, inexact=1.
//  - DONE: out_valid=1. result and flags are held stable until out_ready. On out_valid&&out_ready go to IDLE.
//    in_ready rises the next cycle (no same-cycle accept).
//  - out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
//  - Exponent arithmetic uses 10-bit signed internally; no wrap is allowed.
// STRUCTURE
//  - floatingpoint package additions: typedef fp_flags_t {invalid,overflow,underflow,inexact}; localparam FP_CANON_NAN;
//    enum fp_add_state_t; function Lzc27(input logic [26:0]) returning logic [4:0].
//  - Reuse the package IsZero/IsInf/IsNaN/IsDenorm for classification.
//  - One sub-module: fp_round_rne (combinational: sign, exp, 27-bit significand in; float and flags out).
//  - FSM and datapath registers stay in fp_add_seq.
// TESTING
//  - 3F800000 + 40000000, sub=0 -> 40400000, flags=0, out_valid exactly 6 cycles after accept.
//  - 3F800000 - 3F800000 -> 00000000 (+0), flags=0. Also C0000000 + 3F800000 -> BF800000.
//  - 7F800000 + FF800000 -> 7FC00000, invalid=1, 2-cycle latency. 7FC00001 + 0 -> 7FC00000, invalid=1.
//  - 7F7FFFFF + 7F7FFFFF -> 7F800000, overflow=1, inexact=1.
//  - Rounding: 3F800000 + 33800000 -> 3F800000 (tie, even), inexact=1.
//    3F800000 + 33800001 -> 3F800001. 00000001 + 3F800000 -> 3F800000 (FTZ).
//  - Hold out_ready=0 for 10 cycles: result/flags/out_valid stay stable and in_ready=0.
//    Assert reset in the ALIGN state: out_valid never asserts; the next op (40400000+BF800000) -> 40000000.

Source files
------------

// File: rtl/floatingpoint_pkg.sv
// Single-precision float types, classifiers and helpers shared by the floating-point datapath.
package floatingpoint;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } float;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   // Operand after classification: biased exponent widened, hidden bit made explicit.
   typedef struct packed {
      logic        sign;
      logic [9:0]  exp;
      logic [23:0] sig;
   } fp_unpacked_t;

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      ALIGN,
      ADD,
      NORM,
      ROUND,
      DONE
   } fp_add_state_t;

   localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

   function automatic logic IsZero(input float f);
      return (f.exp == 8'h00) && (f.mant == 23'd0);
   endfunction

   function automatic logic IsInf(input float f);
      return (f.exp == 8'hFF) && (f.mant == 23'd0);
   endfunction

   function automatic logic IsNaN(input float f);
      return (f.exp == 8'hFF) && (f.mant != 23'd0);
   endfunction

   function automatic logic IsDenorm(input float f);
      return (f.exp == 8'h00) && (f.mant != 23'd0);
   endfunction

   function automatic logic [4:0] Lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (v[i]) n = 5'(26 - i);
      end
      return n;
   endfunction

   function automatic fp_unpacked_t Unpack(input float f, input bit ftz);
      fp_unpacked_t u;
      u.sign = f.sign;
      if (IsZero(f) || (ftz && IsDenorm(f))) begin
         u.exp = 10'd0;
         u.sig = 24'd0;
      end else if (IsDenorm(f)) begin
         u.exp = 10'd1;
         u.sig = {1'b0, f.mant};
      end else begin
         u.exp = {2'b00, f.exp};
         u.sig = {1'b1, f.mant};
      end
      return u;
   endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised 27-bit significand {hidden, 23 mant, G, R, S}
// into a single-precision float, with overflow/underflow/inexact detection.
module fp_round_rne
   import floatingpoint::*;
#(
   parameter bit FTZ = 1'b1
) (
   input  logic              sign,
   input  logic signed [9:0] exp_in,
   input  logic [26:0]       sig_in,
   output float              result,
   output fp_flags_t         flags
);

   logic signed [9:0] e_work;
   logic signed [9:0] e_rnd;
   logic signed [9:0] den_sh;
   logic [4:0]        sh;
   logic [26:0]       s_work;
   logic [53:0]       wide;
   logic [24:0]       m_rnd;
   logic              tiny;
   logic              round_up;

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      e_work = exp_in;
      s_work = sig_in;
      tiny   = 1'b0;
      den_sh = 10'sd0;
      sh     = 5'd0;
      wide   = '0;
      result = '0;
      flags  = '0;

      // Gradual underflow: denormalise so the exponent field reads as the minimum.
      if (!FTZ && exp_in <= 10'sd0) begin
         den_sh = 10'sd1 - exp_in;
         sh     = (den_sh > 10'sd27) ? 5'd27 : den_sh[4:0];
         wide   = {sig_in, 27'd0} >> sh;
         s_work = {wide[53:28], wide[27] | (|wide[26:0])};
         e_work = 10'sd1;
         tiny   = 1'b1;
      end

      round_up = s_work[2] & (s_work[1] | s_work[0] | s_work[3]);
      m_rnd    = {1'b0, s_work[26:3]} + {24'd0, round_up};
      e_rnd    = e_work;
      if (m_rnd[24]) begin
         m_rnd = m_rnd >> 1;
         e_rnd = e_work + 10'sd1;
      end

      if (sig_in == 27'd0) begin
         result = {sign, 31'd0};
      end else if (e_rnd >= 10'sd255) begin
         result         = {sign, 8'hFF, 23'd0};
         flags.overflow = 1'b1;
         flags.inexact  = 1'b1;
      end else if (e_rnd <= 10'sd0) begin
         result          = {sign, 31'd0};
         flags.underflow = 1'b1;
         flags.inexact   = 1'b1;
      end else begin
         result          = {sign, (m_rnd[23] ? e_rnd[7:0] : 8'h00), m_rnd[22:0]};
         flags.inexact   = |s_work[2:0];
         flags.underflow = tiny & (|s_work[2:0]);
      end
   end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle single-precision adder/subtractor with valid/ready on both sides,
// one operation in flight, special operands resolved in the unpack step.
module fp_add_seq
   import floatingpoint::*;
#(
   parameter logic [31:0] CANON_NAN = FP_CANON_NAN,
   parameter bit          FTZ       = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  float        a,
   input  float        b,
   input  logic        sub,
   output logic        out_valid,
   input  logic        out_ready,
   output float        result,
   output logic [3:0]  flags
);

   fp_add_state_t     state_q, state_d;
   float              a_q, a_d, b_q, b_d;
   logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d, sign_r_q, sign_r_d;
   logic signed [9:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d, exp_r_q, exp_r_d;
   logic [26:0]       sig_a_q, sig_a_d, sig_b_q, sig_b_d, norm_q, norm_d;
   logic [27:0]       sum_q, sum_d;
   float              result_q, result_d, rnd_result;
   fp_flags_t         flags_q, flags_d, rnd_flags;

   fp_unpacked_t      up_a, up_b;
   logic              a_mag_ge_b;
   logic signed [9:0] align_diff;
   logic [4:0]        align_sh;
   logic [53:0]       align_wide;
   logic [27:0]       add_sum;
   logic [4:0]        lzc;

   assign up_a       = Unpack(a_q, FTZ);
   assign up_b       = Unpack(b_q, FTZ);
   assign a_mag_ge_b = {up_a.exp, up_a.sig} >= {up_b.exp, up_b.sig};

   assign align_diff = exp_a_q - exp_b_q;
   assign align_sh   = (align_diff > 10'sd27) ? 5'd27 : align_diff[4:0];
   assign align_wide = {sig_b_q, 27'd0} >> align_sh;

   // |A| >= |B| after alignment, so effective subtraction never goes negative.
   assign add_sum = (sign_a_q ^ sign_b_q) ? ({1'b0, sig_a_q} - {1'b0, sig_b_q})
                                          : ({1'b0, sig_a_q} + {1'b0, sig_b_q});
   assign lzc     = Lzc27(sum_q[26:0]);

   fp_round_rne #(.FTZ(FTZ)) u_round (
      .sign   (sign_r_q),
      .exp_in (exp_r_q),
      .sig_in (norm_q),
      .result (rnd_result),
      .flags  (rnd_flags)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      sign_r_d  = sign_r_q;
      exp_a_d   = exp_a_q;
      exp_b_d   = exp_b_q;
      exp_r_d   = exp_r_q;
      sig_a_d   = sig_a_q;
      sig_b_d   = sig_b_q;
      norm_d    = norm_q;
      sum_d     = sum_q;
      result_d  = result_q;
      flags_d   = flags_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               b_d.sign = b.sign ^ sub;
               state_d  = UNPACK;
            end
         end
         UNPACK: begin
            if (IsNaN(a_q) || IsNaN(b_q) || (IsInf(a_q) && IsInf(b_q) && (a_q.sign != b_q.sign))) begin
               result_d = CANON_NAN;
               flags_d  = '{invalid: 1'b1, default: 1'b0};
               state_d  = DONE;
            end else if (IsInf(a_q) || IsInf(b_q)) begin
               result_d = IsInf(a_q) ? a_q : b_q;
               flags_d  = '0;
               state_d  = DONE;
            end else begin
               if (a_mag_ge_b) begin
                  sign_a_d = up_a.sign;  exp_a_d = $signed(up_a.exp);  sig_a_d = {up_a.sig, 3'b000};
                  sign_b_d = up_b.sign;  exp_b_d = $signed(up_b.exp);  sig_b_d = {up_b.sig, 3'b000};
               end else begin
                  sign_a_d = up_b.sign;  exp_a_d = $signed(up_b.exp);  sig_a_d = {up_b.sig, 3'b000};
                  sign_b_d = up_a.sign;  exp_b_d = $signed(up_a.exp);  sig_b_d = {up_a.sig, 3'b000};
               end
               state_d = ALIGN;
            end
         end
         ALIGN: begin
            sig_b_d = {align_wide[53:28], align_wide[27] | (|align_wide[26:0])};
            state_d = ADD;
         end
         ADD: begin
            sum_d    = add_sum;
            // Exact zero is +0 unless both addends were -0.
            sign_r_d = (add_sum == 28'd0) ? (sign_a_q & sign_b_q) : sign_a_q;
            state_d  = NORM;
         end
         NORM: begin
            if (sum_q[27]) begin
               norm_d  = {sum_q[27:2], sum_q[1] | sum_q[0]};
               exp_r_d = exp_a_q + 10'sd1;
            end else begin
               norm_d  = sum_q[26:0] << lzc;
               exp_r_d = exp_a_q - $signed({5'd0, lzc});
            end
            state_d = ROUND;
         end
         ROUND: begin
            result_d = rnd_result;
            flags_d  = rnd_flags;
            state_d  = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   // NOTE: datapath registers carry no reset; each is written before the FSM reads it.
   always_ff @(posedge clk) begin
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      sign_r_q <= sign_r_d;
      exp_a_q  <= exp_a_d;
      exp_b_q  <= exp_b_d;
      exp_r_q  <= exp_r_d;
      sig_a_q  <= sig_a_d;
      sig_b_q  <= sig_b_d;
      norm_q   <= norm_d;
      sum_q    <= sum_d;
   end

   assign result = result_q;
   assign flags  = flags_q;

endmodule
